// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// fetch_ctrl : instruction-fetch sequencer between instruction ROM and decoder
// Revision   : 1.0
// ============================================================================
module fetch_ctrl #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 16,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic [AWIDTH-1:0] mem_addr,
  output logic              mem_ready,
  input  logic [DWIDTH-1:0] mem_data,
  input  logic              mem_en,
  output logic [DWIDTH-1:0] ir,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [AWIDTH-1:0] ir_pc,
  input  logic              jmp_req,
  input  logic [AWIDTH-1:0] jmp_addr,
  input  logic              halt,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [AWIDTH-1:0] c_last_addr = AWIDTH'(DEPTH - 1);

  state_t              state_q,     state_d;
  logic [AWIDTH-1:0]   pc_fetch_q,  pc_fetch_d;
  logic [DWIDTH-1:0]   ir_q,        ir_d;
  logic [AWIDTH-1:0]   ir_pc_q,     ir_pc_d;
  logic                err_q,       err_d;
  logic                mem_ready_q, mem_ready_d;
  logic                ir_valid_q,  ir_valid_d;

  always_comb begin
    state_d    = state_q;
    pc_fetch_d = pc_fetch_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (mem_en) begin
          ir_d       = mem_data;
          ir_pc_d    = pc_fetch_q;
          pc_fetch_d = (pc_fetch_q == c_last_addr) ? '0 : pc_fetch_q + 1'b1;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        // Redirect lands in pc_fetch before FETCH, so no wrong-path request is issued.
        if (ir_ready) begin
          if (jmp_req) begin
            if (jmp_addr <= c_last_addr) begin
              pc_fetch_d = jmp_addr;
            end else begin
              pc_fetch_d = '0;
              err_d      = 1'b1;
            end
          end
          state_d = halt ? S_HALT : S_FETCH;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
    mem_ready_d = (state_d == S_FETCH);
    ir_valid_d  = (state_d == S_HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_fetch_q  <= '0;
      ir_q        <= '0;
      ir_pc_q     <= '0;
      err_q       <= 1'b0;
      mem_ready_q <= 1'b0;
      ir_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_fetch_q  <= pc_fetch_d;
      ir_q        <= ir_d;
      ir_pc_q     <= ir_pc_d;
      err_q       <= err_d;
      mem_ready_q <= mem_ready_d;
      ir_valid_q  <= ir_valid_d;
    end
  end

  assign mem_addr  = pc_fetch_q;
  assign mem_ready = mem_ready_q;
  assign ir        = ir_q;
  assign ir_valid  = ir_valid_q;
  assign ir_pc     = ir_pc_q;
  assign err       = err_q;

endmodule
`default_nettype wire
